// File: rtl/branch_seq_pkg.sv
// Shared CPU control package: branch-sequencer state encodings and statistics counter width.
package branch_seq_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T3   = 3'd1;
  localparam logic [2:0] ST_T4   = 3'd2;
  localparam logic [2:0] ST_T5   = 3'd3;
  localparam logic [2:0] ST_T6   = 3'd4;

endpackage

// File: rtl/branch_seq_sat_counter.sv
// Saturating up-counter: advances on inc, holds at all-ones, async active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch control sequencer (T3..T6) with saturating branch statistics.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic             CON,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             PCout,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [2:0]       dbg_state,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       finish;

  // start is a single-cycle request accepted only in IDLE; there is no
  // back-pressure and a start seen while busy is dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_T3;
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ST_T6;
      ST_T6:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_IDLE;
      taken   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T3) taken <= CON;
    end
  end

  assign Gra     = (state_q == ST_T3);
  assign Rout    = (state_q == ST_T3);
  assign CONin   = (state_q == ST_T3);
  assign PCout   = (state_q == ST_T4);
  assign Yin     = (state_q == ST_T4);
  assign Cout    = (state_q == ST_T5);
  assign ADD     = (state_q == ST_T5);
  assign Zin     = (state_q == ST_T5);
  assign Zlowout = (state_q == ST_T6);
  // taken is registered, so PCin remains a pure function of registered state.
  assign PCin    = (state_q == ST_T6) && taken;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_T6);
  assign finish  = (state_q == ST_T6);
  assign dbg_state = state_q;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .Clock (Clock),
    .Clear (Clear),
    .inc   (finish),
    .count (br_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .Clock (Clock),
    .Clear (Clear),
    .inc   (finish && taken),
    .count (taken_count)
  );

endmodule
